// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source: FSM states, pattern
// mode encodings and a helper that sizes counters from their range.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam logic [1:0] MODE_CHECKER = 2'd0;
    localparam logic [1:0] MODE_HGRAD   = 2'd1;
    localparam logic [1:0] MODE_VGRAD   = 2'd2;
    localparam logic [1:0] MODE_INDEX   = 2'd3;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Pixel generator: computes the pattern value for a coordinate and mode and
// holds it in a register until the next load, so the value stays stable
// while the stream is stalled.
module video_pattern_pixel
    import video_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int DATA_WIDTH = 24,
    parameter int CHECK_LOG2 = 3,
    parameter int XW         = 11,
    parameter int YW         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] pixel
);

    localparam int NCH = (DATA_WIDTH + 7) / 8;

    logic [DATA_WIDTH-1:0] pixel_d;
    logic [DATA_WIDTH-1:0] pixel_q;
    logic                  cx_s;
    logic                  cy_s;
    logic [7:0]            x8_s;
    logic [7:0]            y8_s;
    logic [31:0]           index_s;

    assign cx_s    = |((x >> CHECK_LOG2) & XW'(1));
    assign cy_s    = |((y >> CHECK_LOG2) & YW'(1));
    assign x8_s    = 8'(x);
    assign y8_s    = 8'(y);
    assign index_s = 32'(y) * 32'(WIDTH) + 32'(x);

    // Select the pattern value for the coordinate being loaded.
    always_comb begin
        pixel_d = pixel_q;
        if (load) begin
            case (mode)
                MODE_CHECKER: pixel_d = (cx_s ^ cy_s) ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
                MODE_HGRAD:   pixel_d = DATA_WIDTH'({NCH{x8_s}});
                MODE_VGRAD:   pixel_d = DATA_WIDTH'({NCH{y8_s}});
                MODE_INDEX:   pixel_d = DATA_WIDTH'(index_s);
                default:      pixel_d = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            pixel_d = pixel_q;
        end
    end

    // Pixel holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= {DATA_WIDTH{1'b0}};
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/video_pattern_source.sv
// AXI4-Stream test pattern source: emits one frame per start pulse (or
// back-to-back frames while continuous is high) separated by a fixed idle
// gap. The next pixel is prepared at each handshake so tready=1 sustains
// one pixel per cycle.
module video_pattern_source
    import video_pkg::*;
#(
    parameter int WIDTH          = 1280,
    parameter int HEIGHT         = 720,
    parameter int DATA_WIDTH     = 24,
    parameter int CHECK_LOG2     = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int TLAST_PER_LINE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);
    localparam int GW = cnt_w(GAP_CYCLES);

    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic          PER_LINE = (TLAST_PER_LINE != 0);
    // tlast of pixel (0,0) itself: only when a line is one pixel wide.
    localparam logic          FIRST_TLAST = (WIDTH == 1) && (PER_LINE || (HEIGHT == 1));

    state_e        state_d, state_q;
    logic [XW-1:0] x_d, x_q, x_inc_s;
    logic [YW-1:0] y_d, y_q, y_inc_s;
    logic [1:0]    mode_d, mode_q;
    logic [GW-1:0] gap_d, gap_q;
    logic          tvalid_d, tvalid_q;
    logic          tlast_d, tlast_q;
    logic          tuser_d, tuser_q;
    logic          busy_d, busy_q;
    logic          frame_done_d, frame_done_q;
    logic [15:0]   frame_count_d, frame_count_q;
    logic          load_s;

    assign x_inc_s = x_q + XW'(1);
    assign y_inc_s = y_q + YW'(1);

    // Next-state, coordinate and sideband logic for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        mode_d        = mode_q;
        gap_d         = gap_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        load_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d  = ST_ACTIVE;
                    x_d      = {XW{1'b0}};
                    y_d      = {YW{1'b0}};
                    mode_d   = mode;
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b1;
                    tlast_d  = FIRST_TLAST;
                    load_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (tvalid_q && m_axis_tready) begin
                    tuser_d = 1'b0;
                    if (x_q == X_LAST) begin
                        x_d = {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            state_d       = ST_GAP;
                            y_d           = {YW{1'b0}};
                            gap_d         = {GW{1'b0}};
                            tvalid_d      = 1'b0;
                            tlast_d       = 1'b0;
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 16'd1;
                        end else begin
                            y_d     = y_inc_s;
                            tlast_d = (X_LAST == {XW{1'b0}}) && (PER_LINE || (y_inc_s == Y_LAST));
                            load_s  = 1'b1;
                        end
                    end else begin
                        x_d     = x_inc_s;
                        tlast_d = (x_inc_s == X_LAST) && (PER_LINE || (y_q == Y_LAST));
                        load_s  = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_GAP: begin
                if (gap_q == G_LAST) begin
                    if (continuous) begin
                        state_d  = ST_ACTIVE;
                        x_d      = {XW{1'b0}};
                        y_d      = {YW{1'b0}};
                        mode_d   = mode;
                        tvalid_d = 1'b1;
                        tuser_d  = 1'b1;
                        tlast_d  = FIRST_TLAST;
                        load_s   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tuser_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x_q           <= {XW{1'b0}};
            y_q           <= {YW{1'b0}};
            mode_q        <= MODE_CHECKER;
            gap_q         <= {GW{1'b0}};
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mode_q        <= mode_d;
            gap_q         <= gap_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    video_pattern_pixel #(
        .WIDTH      (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CHECK_LOG2 (CHECK_LOG2),
        .XW         (XW),
        .YW         (YW)
    ) u_pixel (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .x     (x_d),
        .y     (y_d),
        .mode  (mode_d),
        .pixel (m_axis_tdata)
    );

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source on a 16x4 frame. Two instances share
// all inputs: one with tlast at frame end, one with tlast at every line end.
module tb_video_pattern_source;

    localparam int W    = 16;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int GAP  = 3;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic        continuous = 1'b0;
    logic        tready     = 1'b0;
    logic [1:0]  mode       = 2'd0;

    logic [23:0] a_tdata, b_tdata;
    logic        a_tvalid, a_tlast, a_tuser, a_busy, a_frame_done;
    logic        b_tvalid, b_tlast, b_tuser, b_busy, b_frame_done;
    logic [15:0] a_frame_count, b_frame_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [23:0] beats [0:NPIX-1];

    video_pattern_source #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24), .CHECK_LOG2(2),
        .GAP_CYCLES(GAP), .TLAST_PER_LINE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .mode(mode),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
        .m_axis_tuser(a_tuser), .m_axis_tready(tready), .busy(a_busy),
        .frame_done(a_frame_done), .frame_count(a_frame_count)
    );

    video_pattern_source #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24), .CHECK_LOG2(2),
        .GAP_CYCLES(GAP), .TLAST_PER_LINE(1)
    ) dut_line (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .mode(mode),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
        .m_axis_tuser(b_tuser), .m_axis_tready(tready), .busy(b_busy),
        .frame_done(b_frame_done), .frame_count(b_frame_count)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_pixel(input logic [1:0] md, input int x, input int y);
        logic [7:0] b;
        case (md)
            2'd0: return ((((x >> 2) + (y >> 2)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            2'd1: begin b = x[7:0]; return {b, b, b}; end
            2'd2: begin b = y[7:0]; return {b, b, b}; end
            default: return 24'(y * W + x);
        endcase
    endfunction

    // Consume one frame (first beat already presented), check every beat and
    // stall, then check the idle gap that follows.
    task automatic run_frame(input logic [1:0] md, input bit rnd, input logic [1:0] next_md,
                             input bit drop_cont, input logic [15:0] exp_fc);
        int n = 0;
        int cyc = 0;
        int x, y;
        bit stalled = 1'b0;
        logic [23:0] hd;
        logic hl, hu;
        check_eq("first_valid", a_tvalid, 1);
        while (n < NPIX && cyc < 1000) begin
            if (stalled) begin
                check_eq("stall_valid", a_tvalid, 1);
                check_eq("stall_data", a_tdata, hd);
                check_eq("stall_last", a_tlast, hl);
                check_eq("stall_user", a_tuser, hu);
            end
            start = (n == 10);
            if (n >= 10) mode = md ^ 2'd1;
            if (drop_cont && n >= 30) continuous = 1'b0;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_tvalid && tready) begin
                x = n % W;
                y = n / W;
                check_eq("data", a_tdata, exp_pixel(md, x, y));
                check_eq("tuser", a_tuser, (n == 0));
                check_eq("tlast_frame", a_tlast, (n == NPIX - 1));
                check_eq("tlast_line", b_tlast, (x == W - 1));
                beats[n] = a_tdata;
                n++;
                stalled = 1'b0;
            end else if (a_tvalid) begin
                stalled = 1'b1;
                hd = a_tdata;
                hl = a_tlast;
                hu = a_tuser;
            end else begin
                check_eq("valid_hole", a_tvalid, 1);
            end
            step();
            cyc++;
        end
        check_eq("frame_beats", n, NPIX);
        start  = 1'b0;
        mode   = next_md;
        tready = 1'b1;
        check_eq("frame_count", a_frame_count, exp_fc);
        for (int g = 0; g < GAP; g++) begin
            check_eq("gap_valid", a_tvalid, 0);
            check_eq("gap_done", a_frame_done, (g == 0));
            check_eq("gap_busy", a_busy, 1);
            step();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", a_tvalid, 0);
        check_eq("rst_data", a_tdata, 0);
        check_eq("rst_last", a_tlast, 0);
        check_eq("rst_user", a_tuser, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_frame_done, 0);
        check_eq("rst_count", a_frame_count, 0);
        rst_n = 1'b1;
        step();
        check_eq("idle_busy0", a_busy, 0);

        // Index pattern, full throughput.
        mode = 2'd3; start = 1'b1; step(); start = 1'b0;
        run_frame(2'd3, 1'b0, 2'd0, 1'b0, 16'd1);
        check_eq("idle_busy1", a_busy, 0);
        step();
        check_eq("idle_valid1", a_tvalid, 0);

        // Checkerboard with hand-picked pixels.
        mode = 2'd0; start = 1'b1; step(); start = 1'b0;
        run_frame(2'd0, 1'b0, 2'd3, 1'b0, 16'd2);
        check_eq("chk_0_0", beats[0], 24'hFFFFFF);
        check_eq("chk_4_0", beats[4], 24'h000000);
        check_eq("chk_8_0", beats[8], 24'hFFFFFF);
        check_eq("chk_0_1", beats[16], 24'hFFFFFF);
        check_eq("chk_4_1", beats[20], 24'h000000);
        check_eq("idle_busy2", a_busy, 0);

        // Index pattern under random backpressure.
        mode = 2'd3; start = 1'b1; step(); start = 1'b0;
        run_frame(2'd3, 1'b1, 2'd1, 1'b0, 16'd3);
        check_eq("idle_busy3", a_busy, 0);

        // Continuous: three frames back to back, dropped during the third.
        mode = 2'd1; continuous = 1'b1; step();
        run_frame(2'd1, 1'b0, 2'd2, 1'b0, 16'd4);
        run_frame(2'd2, 1'b1, 2'd3, 1'b0, 16'd5);
        run_frame(2'd3, 1'b0, 2'd3, 1'b1, 16'd6);
        check_eq("cont_end_busy", a_busy, 0);
        step();
        check_eq("cont_end_valid", a_tvalid, 0);

        // Reset in the middle of a frame.
        mode = 2'd3; tready = 1'b1; start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        check_eq("pre_reset_data", a_tdata, 20);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", a_tvalid, 0);
        check_eq("mid_rst_busy", a_busy, 0);
        check_eq("mid_rst_data", a_tdata, 0);
        check_eq("mid_rst_count", a_frame_count, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        mode = 2'd3; start = 1'b1; step(); start = 1'b0;
        check_eq("post_rst_data", a_tdata, 0);
        check_eq("post_rst_user", a_tuser, 1);
        run_frame(2'd3, 1'b0, 2'd3, 1'b0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
